edc_error_injector: RTL

Programmable error-injection engine that drives the EDC error-write ports (error_dwe/error_pwe/error_din/error_pin/error_addr) of the cache inside PipelineMIPS. Replaces hand-sequenced per-clock stimulus with a start/busy/done-controlled engine. Injects into a run of consecutive cache entries using one of four corruption patterns. Generalised in data width, check-bit width, address width and inter-injection spacing.

---
 rtl/edc_error_injector.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/edc_error_injector.sv
// edc_error_injector: start/busy/done controlled engine that drives the cache
// EDC error-write ports with one of four corruption patterns over a run of
// consecutive entries. All outputs are registered.
//
// Handshake: start is a one-cycle request that is only sampled while idle
// (busy=0). busy rises the cycle after an accepted start. It stays high up to
// and including the single-cycle done pulse that marks normal completion.
// abort ends a run at once and produces no done pulse.
module edc_error_injector #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned PAR_W     = 16,
   parameter int unsigned ADDR_W    = 9,
   parameter int unsigned GAP       = 0,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic [DATA_W-1:0] mask_data,
   input  logic [PAR_W-1:0]  mask_par,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   inj_cnt,
   output logic              error_dwe,
   output logic              error_pwe,
   output logic [DATA_W-1:0] error_din,
   output logic [PAR_W-1:0]  error_pin,
   output logic [ADDR_W-1:0] error_addr,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_INJECT, S_GAPW, S_FIN} state_t;

   localparam logic [1:0]  M_FIXED_DATA = 2'd0;
   localparam logic [1:0]  M_FIXED_PAR  = 2'd1;
   localparam logic [1:0]  M_WALK_DATA  = 2'd2;
   localparam logic [1:0]  M_RAND_DATA  = 2'd3;
   localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
   localparam int          GAP_I        = int'(GAP);
   localparam logic [7:0]  GAP_LAST     = (GAP_I > 0) ? 8'(GAP_I - 1) : 8'd0;

   state_t              state_q, state_d;
   logic [1:0]          mode_q;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W:0]     count_q;
   logic [DATA_W-1:0]   mdata_q;
   logic [PAR_W-1:0]    mpar_q;
   logic [7:0]          gap_q;
   logic [31:0]         lfsr_q;

   // Run parameters seen by the injection datapath: on the accepting edge the
   // first strobe is built straight from the inputs, afterwards from the
   // latched copies.
   logic [1:0]          mode_eff;
   logic [ADDR_W-1:0]   base_eff;
   logic [DATA_W-1:0]   mdata_eff;
   logic [PAR_W-1:0]    mpar_eff;
   logic [ADDR_W:0]     k_eff;

   logic                dwe_d, pwe_d;
   logic [DATA_W-1:0]   din_d, walk_mask, rand_mask;
   logic [PAR_W-1:0]    pin_d;
   logic [15:0]         rand_idx;
   logic [31:0]         lfsr_step;

   assign dbg_state = state_q;

   // Next-state decision; abort wins over everything outside IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = (count == '0) ? S_FIN : S_INJECT;
         end
         S_INJECT: begin
            if (abort)                  state_d = S_IDLE;
            else if (inj_cnt == count_q) state_d = S_FIN;
            else if (GAP_I == 0)        state_d = S_INJECT;
            else                        state_d = S_GAPW;
         end
         S_GAPW: begin
            if (abort)              state_d = S_IDLE;
            else if (gap_q == 8'd0) state_d = S_INJECT;
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pattern generation for the injection about to be issued.
   always_comb begin
      mode_eff  = (state_q == S_IDLE) ? mode      : mode_q;
      base_eff  = (state_q == S_IDLE) ? base_addr : base_q;
      mdata_eff = (state_q == S_IDLE) ? mask_data : mdata_q;
      mpar_eff  = (state_q == S_IDLE) ? mask_par  : mpar_q;
      k_eff     = (state_q == S_IDLE) ? '0        : inj_cnt;

      // Walking mask: bit i set when i <= k, saturating to all ones.
      walk_mask = '0;
      for (int i = 0; i < int'(DATA_W); i++) begin
         walk_mask[i] = (int'(k_eff) >= i);
      end

      rand_idx  = lfsr_q[15:0] % 16'(DATA_W);
      rand_mask = {{(DATA_W-1){1'b0}}, 1'b1} << rand_idx;
      lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

      dwe_d = 1'b0;
      pwe_d = 1'b0;
      din_d = '0;
      pin_d = '0;
      case (mode_eff)
         M_FIXED_DATA: begin dwe_d = 1'b1; din_d = mdata_eff; end
         M_FIXED_PAR:  begin pwe_d = 1'b1; pin_d = mpar_eff;  end
         M_WALK_DATA:  begin dwe_d = 1'b1; din_d = walk_mask; end
         M_RAND_DATA:  begin dwe_d = 1'b1; din_d = rand_mask; end
         default:      begin dwe_d = 1'b0; end
      endcase
   end

   // State, run latches and registered outputs; strobes and masks default to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mode_q     <= '0;
         base_q     <= '0;
         count_q    <= '0;
         mdata_q    <= '0;
         mpar_q     <= '0;
         gap_q      <= '0;
         lfsr_q     <= LFSR_SEED;
         busy       <= 1'b0;
         done       <= 1'b0;
         inj_cnt    <= '0;
         error_dwe  <= 1'b0;
         error_pwe  <= 1'b0;
         error_din  <= '0;
         error_pin  <= '0;
         error_addr <= '0;
      end else begin
         state_q   <= state_d;
         busy      <= (state_d != S_IDLE);
         done      <= (state_d == S_FIN);
         error_dwe <= 1'b0;
         error_pwe <= 1'b0;
         error_din <= '0;
         error_pin <= '0;

         if (state_q == S_IDLE && start) begin
            mode_q  <= mode;
            base_q  <= base_addr;
            count_q <= count;
            mdata_q <= mask_data;
            mpar_q  <= mask_par;
            inj_cnt <= '0;
         end

         if (state_d == S_INJECT) begin
            error_dwe  <= dwe_d;
            error_pwe  <= pwe_d;
            error_din  <= din_d;
            error_pin  <= pin_d;
            error_addr <= base_eff + k_eff[ADDR_W-1:0];
            inj_cnt    <= k_eff + 1'b1;
            if (mode_eff == M_RAND_DATA) lfsr_q <= lfsr_step;
         end

         if (state_q == S_INJECT && state_d == S_GAPW) gap_q <= GAP_LAST;
         else if (state_q == S_GAPW)                   gap_q <= gap_q - 8'd1;
      end
   end

endmodule
